// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller.
// Opcodes, FSM states, datapath select encodings and the control bundle.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC,
        ALU_WB,
        ADDI_EX,
        ADDI_WB,
        BRANCH,
        JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_ADDI  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RSVD   = 2'b11
    } pc_source_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       retire;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        return is_mem_op(op) || is_branch(op) || (op == OP_RTYPE)
            || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode for the multi-cycle controller.
// Maps current state, opcode and memory ready onto every datapath control.
module mc_output_decode
    import mips_mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Every control defaults low; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !op_legal(opcode);
            end
            MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADDI;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a        = 1'b1;
                ctrl.alu_src_b        = SRCB_RT;
                ctrl.alu_op           = ALU_SUB;
                ctrl.pc_source        = PC_ALUOUT;
                ctrl.retire           = 1'b1;
                ctrl.pc_write_cond    = (opcode == OP_BEQ);
                ctrl.pc_write_cond_ne = (opcode == OP_BNE);
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the MIPS core.
// Holds the state register and next-state logic; outputs come from the decoder.
module multicycle_control
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_cond_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal_op
);

    state_t state_r;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   rdy_gated;

    // Ready is masked during reset so no fetch strobes leak out.
    assign rdy_gated = mem_ready & rst_n;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= FETCH;
        else        state_r <= state_nxt;
    end

    // Next-state selection; memory states hold until ready.
    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            FETCH:   if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_mem_op(opcode):   state_nxt = MEM_ADR;
                    (opcode == OP_RTYPE): state_nxt = EXEC;
                    (opcode == OP_ADDI):  state_nxt = ADDI_EX;
                    is_branch(opcode):   state_nxt = BRANCH;
                    (opcode == OP_J):     state_nxt = JUMP;
                    default:             state_nxt = FETCH;
                endcase
            end
            MEM_ADR: state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:  if (mem_ready) state_nxt = MEM_WB;
            MEM_WB:  state_nxt = FETCH;
            MEM_WR:  if (mem_ready) state_nxt = FETCH;
            EXEC:    state_nxt = ALU_WB;
            ALU_WB:  state_nxt = FETCH;
            ADDI_EX: state_nxt = ADDI_WB;
            ADDI_WB: state_nxt = FETCH;
            BRANCH:  state_nxt = FETCH;
            JUMP:    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    mc_output_decode u_dec (
        .state     (state_r),
        .opcode    (opcode),
        .mem_ready (rdy_gated),
        .ctrl      (ctrl)
    );

    assign pc_write         = ctrl.pc_write;
    assign pc_write_cond    = ctrl.pc_write_cond;
    assign pc_write_cond_ne = ctrl.pc_write_cond_ne;
    assign iord             = ctrl.iord;
    assign mem_read         = ctrl.mem_read;
    assign mem_write        = ctrl.mem_write;
    assign ir_write         = ctrl.ir_write;
    assign reg_dst          = ctrl.reg_dst;
    assign mem_to_reg       = ctrl.mem_to_reg;
    assign reg_write        = ctrl.reg_write;
    assign alu_src_a        = ctrl.alu_src_a;
    assign alu_src_b        = ctrl.alu_src_b;
    assign alu_op           = ctrl.alu_op;
    assign pc_source        = ctrl.pc_source;
    assign retire           = ctrl.retire;
    assign illegal_op       = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Directed vector table, reset corner cases and a randomized instruction stream.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_write_cond_ne, iord;
    logic       mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, retire, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [18:0] act;

    int ncmp = 0;
    int nerr = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_write_cond_ne(pc_write_cond_ne), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .retire(retire), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, pc_write_cond, pc_write_cond_ne, iord,
                  mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  retire, illegal_op};

    function automatic logic [18:0] ov(
        input logic pw, pwc, pwcn, io, mrd, mwr, irw, rdst, m2r, rw, sa,
        input logic [1:0] sb, aop, ps,
        input logic ret, ill);
        return {pw, pwc, pwcn, io, mrd, mwr, irw, rdst, m2r, rw, sa,
                sb, aop, ps, ret, ill};
    endfunction

    //                     pw c cn io rd wr ir dst m2r rw sa sb    aop   ps    rt il
    localparam logic [18:0] FW  = ov(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [18:0] FR  = ov(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [18:0] DEC = ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    localparam logic [18:0] DIL = ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
    localparam logic [18:0] ADR = ov(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    localparam logic [18:0] MRD = ov(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [18:0] MWB = ov(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [18:0] MW0 = ov(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [18:0] MW1 = ov(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [18:0] EXE = ov(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    localparam logic [18:0] RWB = ov(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [18:0] AEX = ov(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0);
    localparam logic [18:0] AWB = ov(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [18:0] BEQ = ov(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    localparam logic [18:0] BNE = ov(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    localparam logic [18:0] JMP = ov(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] op, input logic mr,
                       input logic [18:0] e, input string nm);
        vec_t v;
        v.op = op; v.mr = mr; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic check(input logic [18:0] e, input string nm);
        ncmp++;
        if (act !== e) begin
            nerr++;
            $display("FAIL %s: got %b want %b", nm, act, e);
        end
    endtask

    // Reference model: instruction class plus step count within it.
    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3;
    localparam int C_ADDI = 4, C_BEQ = 5, C_BNE = 6, C_J = 7;

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b001000: return C_ADDI;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int base_cycles(input int c);
        case (c)
            C_LW:                return 5;
            C_BEQ, C_BNE, C_J:   return 3;
            default:             return 4;
        endcase
    endfunction

    function automatic logic [18:0] exp_out(input int c, input int step,
                                            input logic mr);
        case (step)
            0: return mr ? FR : FW;
            1: return (c == C_ILL) ? DIL : DEC;
            2: case (c)
                   C_LW, C_SW: return ADR;
                   C_R:        return EXE;
                   C_ADDI:     return AEX;
                   C_BEQ:      return BEQ;
                   C_BNE:      return BNE;
                   default:    return JMP;
               endcase
            3: case (c)
                   C_LW:    return MRD;
                   C_SW:    return mr ? MW1 : MW0;
                   C_R:     return RWB;
                   default: return AWB;
               endcase
            default: return MWB;
        endcase
    endfunction

    function automatic int next_step(input int c, input int step,
                                     input logic mr);
        case (step)
            0: return mr ? 1 : 0;
            1: return (c == C_ILL) ? 0 : 2;
            2: return (c == C_BEQ || c == C_BNE || c == C_J) ? 0 : 3;
            3: case (c)
                   C_LW:    return mr ? 4 : 3;
                   C_SW:    return mr ? 0 : 3;
                   default: return 0;
               endcase
            default: return 0;
        endcase
    endfunction

    logic [5:0] legal_ops [7] = '{6'h23, 6'h2b, 6'h00, 6'h08,
                                  6'h04, 6'h05, 6'h02};

    initial begin
        rst_n = 1'b0;
        opcode = 6'h00;
        mem_ready = 1'b0;

        add(6'h23, 1, FR,  "lw_fetch");
        add(6'h23, 1, DEC, "lw_decode");
        add(6'h23, 1, ADR, "lw_memadr");
        add(6'h23, 1, MRD, "lw_memrd");
        add(6'h23, 1, MWB, "lw_memwb");
        add(6'h2b, 1, FR,  "sw_fetch");
        add(6'h2b, 1, DEC, "sw_decode");
        add(6'h2b, 1, ADR, "sw_memadr");
        add(6'h2b, 0, MW0, "sw_wait1");
        add(6'h2b, 0, MW0, "sw_wait2");
        add(6'h2b, 1, MW1, "sw_done");
        add(6'h04, 1, FR,  "beq_fetch");
        add(6'h04, 1, DEC, "beq_decode");
        add(6'h04, 1, BEQ, "beq_branch");
        add(6'h05, 1, FR,  "bne_fetch");
        add(6'h05, 1, DEC, "bne_decode");
        add(6'h05, 1, BNE, "bne_branch");
        add(6'h3f, 1, FR,  "ill_fetch");
        add(6'h3f, 1, DIL, "ill_decode");
        add(6'h3f, 0, FW,  "ill_back_fetch");
        add(6'h00, 1, FR,  "r_fetch");
        add(6'h00, 1, DEC, "r_decode");
        add(6'h00, 1, EXE, "r_exec");
        add(6'h00, 1, RWB, "r_wb");
        add(6'h08, 1, FR,  "addi_fetch");
        add(6'h08, 1, DEC, "addi_decode");
        add(6'h08, 1, AEX, "addi_ex");
        add(6'h08, 1, AWB, "addi_wb");
        add(6'h02, 0, FW,  "j_fetch_wait");
        add(6'h02, 1, FR,  "j_fetch");
        add(6'h02, 1, DEC, "j_decode");
        add(6'h02, 1, JMP, "j_jump");

        // Reset state, with fetch strobes masked even if memory is ready.
        @(negedge clk);
        #1 check(FW, "reset_state");
        mem_ready = 1'b1;
        #1 check(FW, "reset_ready_masked");
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            opcode = tbl[i].op;
            mem_ready = tbl[i].mr;
            #1 check(tbl[i].exp, tbl[i].name);
        end

        // Reset during EXEC of an R-type aborts it cleanly.
        @(negedge clk);
        opcode = 6'h00;
        mem_ready = 1'b1;
        #1 check(FR, "abort_fetch");
        @(negedge clk);
        #1 check(DEC, "abort_decode");
        @(negedge clk);
        #1 check(EXE, "abort_exec");
        rst_n = 1'b0;
        #1 check(FW, "abort_in_reset");
        @(negedge clk);
        #1 check(FW, "abort_next_cycle");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 check(FR, "abort_refetch");

        // Randomized instruction stream against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        begin
            int step = 0;
            int cyc = 0;
            int waits = 0;
            int c = C_ILL;
            int nstep;
            logic [18:0] e;
            for (int n = 0; n < 4000; n++) begin
                @(negedge clk);
                if (step == 0 && cyc == 0) begin
                    if ($urandom_range(0, 7) == 0)
                        opcode = 6'($urandom_range(0, 63));
                    else
                        opcode = legal_ops[$urandom_range(0, 6)];
                    c = classify(opcode);
                end
                mem_ready = ($urandom_range(0, 3) != 0);
                #1;
                e = exp_out(c, step, mem_ready);
                check(e, "rand_ctrl");
                cyc++;
                if (!mem_ready && (step == 0 ||
                    (step == 3 && (c == C_LW || c == C_SW))))
                    waits++;
                if (e[1]) begin
                    ncmp++;
                    if (cyc != base_cycles(c) + waits) begin
                        nerr++;
                        $display("FAIL rand_latency: got %0d cycles want %0d",
                                 cyc, base_cycles(c) + waits);
                    end
                end
                nstep = next_step(c, step, mem_ready);
                if (nstep == 0 && step != 0) begin
                    cyc = 0;
                    waits = 0;
                end
                step = nstep;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
